// File: rtl/uart_cmd_decoder.sv
// Frame decoder behind the UART receiver: SYNC, ID, LEN, payload, XOR checksum.
// Good frames raise a one-cycle command strobe. Bad or stalled frames raise an error strobe.
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 16000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Cmd_Valid,
  output logic [7:0]  o_Cmd_Id,
  output logic [3:0]  o_Cmd_Len,
  output logic [63:0] o_Cmd_Payload,
  output logic        o_Frame_Err,
  output logic [1:0]  o_Err_Code
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  MAX_LEN_B    = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_CMD     = 3'd1,
    s_LEN     = 3'd2,
    s_PAYLOAD = 3'd3,
    s_CHECK   = 3'd4
  } state_t;

  state_t      state_reg;
  logic [7:0]  id_reg;
  logic [3:0]  len_reg;
  logic [63:0] shadow_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  acc_reg;
  logic [15:0] timer_reg;
  logic        frame_busy;
  logic        timeout_hit;

  assign frame_busy  = (state_reg == s_CMD) || (state_reg == s_LEN) ||
                       (state_reg == s_PAYLOAD) || (state_reg == s_CHECK);
  assign timeout_hit = frame_busy && (timer_reg == TIMEOUT_LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg     <= s_IDLE;
      id_reg        <= '0;
      len_reg       <= '0;
      shadow_reg    <= '0;
      idx_reg       <= '0;
      acc_reg       <= '0;
      timer_reg     <= '0;
      o_Cmd_Valid   <= 1'b0;
      o_Cmd_Id      <= '0;
      o_Cmd_Len     <= '0;
      o_Cmd_Payload <= '0;
      o_Frame_Err   <= 1'b0;
      o_Err_Code    <= '0;
    end else begin
      o_Cmd_Valid <= 1'b0;
      o_Frame_Err <= 1'b0;

      if (i_Rx_DV || state_reg == s_IDLE) timer_reg <= '0;
      else                                timer_reg <= timer_reg + 16'd1;

      case (state_reg)
        s_IDLE: begin
          if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_reg <= s_CMD;
        end
        s_CMD: begin
          if (i_Rx_DV) begin
            id_reg    <= i_Rx_Byte;
            acc_reg   <= i_Rx_Byte;
            state_reg <= s_LEN;
          end
        end
        s_LEN: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte > MAX_LEN_B) begin
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= 2'd2;
              state_reg   <= s_IDLE;
            end else begin
              len_reg    <= i_Rx_Byte[3:0];
              acc_reg    <= acc_reg ^ i_Rx_Byte;
              shadow_reg <= '0;
              idx_reg    <= '0;
              state_reg  <= (i_Rx_Byte == 8'd0) ? s_CHECK : s_PAYLOAD;
            end
          end
        end
        s_PAYLOAD: begin
          if (i_Rx_DV) begin
            shadow_reg[8*idx_reg +: 8] <= i_Rx_Byte;
            acc_reg <= acc_reg ^ i_Rx_Byte;
            idx_reg <= idx_reg + 3'd1;
            if ({1'b0, idx_reg} == len_reg - 4'd1) state_reg <= s_CHECK;
          end
        end
        s_CHECK: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte == acc_reg) begin
              o_Cmd_Valid   <= 1'b1;
              o_Cmd_Id      <= id_reg;
              o_Cmd_Len     <= len_reg;
              o_Cmd_Payload <= shadow_reg;
            end else begin
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= 2'd1;
            end
            state_reg <= s_IDLE;
          end
        end
        default: state_reg <= s_IDLE;
      endcase

      // A byte landing on the timeout cycle takes priority over the timeout.
      if (!i_Rx_DV && timeout_hit) begin
        o_Frame_Err <= 1'b1;
        o_Err_Code  <= 2'd3;
        state_reg   <= s_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed checks for uart_cmd_decoder: good/bad frames, length and timeout errors, noise, reset.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        cmd_valid;
  logic [7:0]  cmd_id;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;
  logic        frame_err;
  logic [1:0]  err_code;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_cnt    = 0;
  int err_cnt      = 0;
  int both_seen    = 0;
  int v_base, e_base;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .MAX_LEN(8), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Cmd_Valid   (cmd_valid),
    .o_Cmd_Id      (cmd_id),
    .o_Cmd_Len     (cmd_len),
    .o_Cmd_Payload (cmd_payload),
    .o_Frame_Err   (frame_err),
    .o_Err_Code    (err_code)
  );

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) valid_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (cmd_valid === 1'b1 && frame_err === 1'b1) both_seen++;
  end

  task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end else begin
      $display("[TB] ok   %s: %h", tag, actual);
    end
  endtask

  // Caller sits at a negedge; the byte is sampled on the next posedge and we return at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] id, input logic [3:0] len, input logic [63:0] pl);
    check_value({tag, "_id"}, 64'(cmd_id), 64'(id));
    check_value({tag, "_len"}, 64'(cmd_len), 64'(len));
    check_value({tag, "_payload"}, cmd_payload, pl);
  endtask

  task automatic mark();
    v_base = valid_cnt;
    e_base = err_cnt;
  endtask

  task automatic send_good_a();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_value("rst_valid", 64'(cmd_valid), 64'd0);
    check_value("rst_err", 64'(frame_err), 64'd0);
    check_value("rst_code", 64'(err_code), 64'd0);
    check_cmd("rst", 8'h00, 4'd0, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good frame, back-to-back bytes
    mark();
    send_good_a();
    check_value("good_a_strobe", 64'(cmd_valid), 64'd1);
    check_cmd("good_a", 8'h10, 4'd3, 64'h0000_0000_0033_2211);
    @(negedge clk);
    check_value("good_a_vcount", 64'(valid_cnt - v_base), 64'd1);
    check_value("good_a_ecount", 64'(err_cnt - e_base), 64'd0);

    // Bad checksum: expected 44, send 00
    mark();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01); send_byte(8'h55); send_byte(8'h00);
    check_value("badsum_err", 64'(frame_err), 64'd1);
    check_value("badsum_code", 64'(err_code), 64'd1);
    check_cmd("badsum_hold", 8'h10, 4'd3, 64'h0000_0000_0033_2211);
    @(negedge clk);
    check_value("badsum_vcount", 64'(valid_cnt - v_base), 64'd0);
    check_value("badsum_ecount", 64'(err_cnt - e_base), 64'd1);

    // Zero-length frame
    mark();
    send_byte(8'hA5); send_byte(8'h42); send_byte(8'h00); send_byte(8'h42);
    check_value("zlen_strobe", 64'(cmd_valid), 64'd1);
    check_cmd("zlen", 8'h42, 4'd0, 64'd0);
    @(negedge clk);
    check_value("zlen_vcount", 64'(valid_cnt - v_base), 64'd1);

    // Length 9 is rejected, then a good frame
    mark();
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h09);
    check_value("len_err", 64'(frame_err), 64'd1);
    check_value("len_code", 64'(err_code), 64'd2);
    send_good_a();
    check_value("len_after_strobe", 64'(cmd_valid), 64'd1);
    check_cmd("len_after", 8'h10, 4'd3, 64'h0000_0000_0033_2211);
    check_value("len_err_code_hold", 64'(err_code), 64'd2);
    @(negedge clk);
    check_value("len_ecount", 64'(err_cnt - e_base), 64'd1);

    // Stall: timeout exactly TO clocks after the last byte
    mark();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA);
    repeat (TO - 1) @(negedge clk);
    check_value("to_not_early", 64'(frame_err), 64'd0);
    @(negedge clk);
    check_value("to_err", 64'(frame_err), 64'd1);
    check_value("to_code", 64'(err_code), 64'd3);
    @(negedge clk);
    check_value("to_ecount", 64'(err_cnt - e_base), 64'd1);

    // Byte on the timeout cycle wins; frame completes (10^02^AA^BB = 03)
    mark();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'hBB);
    check_value("race_no_err", 64'(frame_err), 64'd0);
    send_byte(8'h03);
    check_value("race_strobe", 64'(cmd_valid), 64'd1);
    check_cmd("race", 8'h10, 4'd2, 64'h0000_0000_0000_BBAA);
    @(negedge clk);
    check_value("race_ecount", 64'(err_cnt - e_base), 64'd0);

    // Garbage before a good frame
    mark();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    repeat (3) @(negedge clk);
    send_byte(8'hA5); send_byte(8'h42); send_byte(8'h00); send_byte(8'h42);
    @(negedge clk);
    check_value("noise_vcount", 64'(valid_cnt - v_base), 64'd1);
    check_value("noise_ecount", 64'(err_cnt - e_base), 64'd0);
    check_cmd("noise", 8'h42, 4'd0, 64'd0);

    // Reset mid-frame: outputs clear, no strobes, then a fresh frame decodes
    send_good_a();
    @(negedge clk);
    mark();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
    rst = 1'b1;
    #1;
    check_cmd("midrst", 8'h00, 4'd0, 64'd0);
    check_value("midrst_code", 64'(err_code), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (TO + 5) @(negedge clk);
    check_value("midrst_vcount", 64'(valid_cnt - v_base), 64'd0);
    check_value("midrst_ecount", 64'(err_cnt - e_base), 64'd0);
    mark();
    send_good_a();
    check_value("fresh_strobe", 64'(cmd_valid), 64'd1);
    check_cmd("fresh", 8'h10, 4'd3, 64'h0000_0000_0033_2211);
    @(negedge clk);
    check_value("fresh_vcount", 64'(valid_cnt - v_base), 64'd1);

    check_value("strobe_mutex", 64'(both_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-level command frame decoder that sits directly downstream of the UART receiver on the motorboard FPGA. Consumes the receiver's one-cycle byte strobe and byte, hunts for a sync byte, and assembles a frame of command ID, length, payload and XOR checksum. Validated commands are presented as a one-cycle strobe with held ID/length/payload for the motor control logic. Malformed or stalled frames are reported on an error strobe.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 8: maximum payload bytes; fixed at 8 (payload bus is 64 bits).
- TIMEOUT_CLKS, 16000: inter-byte timeout in clocks (1 ms at 16 MHz); must be < 65536.

Ports:
- i_Clock  in  1  system clock (16 MHz).
- i_Reset  in  1  asynchronous, active-high reset.
- i_Rx_DV  in  1  byte-valid strobe from the UART receiver; one cycle per byte.
- i_Rx_Byte  in  8  received byte; valid when i_Rx_DV=1.
- o_Cmd_Valid  out  1  one-cycle strobe: good frame decoded.
- o_Cmd_Id  out  8  command ID of the last good frame.
- o_Cmd_Len  out  4  payload length of the last good frame (0..8).
- o_Cmd_Payload  out  64  payload; byte k at [8k+7:8k]; unused bytes zero.
- o_Frame_Err  out  1  one-cycle strobe: frame discarded.
- o_Err_Code  out  2  reason for the last error: 1 checksum, 2 length, 3 timeout; 0 after reset.

## Operation
- States: s_IDLE, s_CMD, s_LEN, s_PAYLOAD, s_CHECK.
- s_IDLE: on i_Rx_DV with byte == SYNC_BYTE -> s_CMD. Other bytes are ignored silently with no error.
- s_CMD: on i_Rx_DV, store the ID, set checksum accumulator = byte -> s_LEN.
- s_LEN: on i_Rx_DV:
  - If byte > MAX_LEN -> pulse o_Frame_Err with code 2 -> s_IDLE.
  - Otherwise store the length, accumulator ^= byte, clear the payload shadow register and byte index.
  - Go to s_PAYLOAD if length > 0, else s_CHECK.
- s_PAYLOAD: on i_Rx_DV, write the byte into shadow[8*idx+:8], accumulator ^= byte, idx++. When idx reaches length-1 on a write -> s_CHECK.
- s_CHECK: on i_Rx_DV:
  - Byte == accumulator: copy ID, length and shadow payload to the outputs, pulse o_Cmd_Valid.
  - Otherwise pulse o_Frame_Err with code 1.
  - Either way -> s_IDLE.
- Timeout counter (16 bit):
  - Cleared on every i_Rx_DV and while in s_IDLE.
  - Otherwise increments each clock.
  - When it equals TIMEOUT_CLKS-1 in a non-IDLE state: pulse o_Frame_Err with code 3 -> s_IDLE.
- Simultaneous byte arrival and timeout: the byte wins; it is processed and the counter clears.
- A sync byte arriving mid-frame is treated as data. There is no resynchronisation until the frame completes or times out.
- o_Cmd_Id, o_Cmd_Len and o_Cmd_Payload change only on a good frame. They hold otherwise, including after errors.
- o_Err_Code updates only when o_Frame_Err pulses.
- Unknown or illegal state -> s_IDLE.

## Timing
- Reset (async assert; deassert takes effect on the next i_Clock edge):
  - All outputs 0.
  - State s_IDLE.
  - Counters, accumulator and shadow register cleared.
- Reset mid-frame discards the partial frame with no error strobe.
- All outputs are registered.
- o_Cmd_Valid and o_Frame_Err:
  - Rise one clock after the i_Rx_DV cycle that completes or invalidates the frame.
  - Stay high for exactly 1 cycle.
  - Are never high together.
- Data outputs are valid in the same cycle o_Cmd_Valid is high.
- Timeout strobe: TIMEOUT_CLKS clocks after the last accepted byte (the cycle the counter hits TIMEOUT_CLKS-1, plus 1 register).
- No back-pressure: the decoder accepts a byte on every i_Rx_DV, including back-to-back bytes on consecutive cycles.

## Test plan
- Good frame A5 10 03 11 22 33 (checksum 10^03^11^22^33=13), then byte 13:
  - o_Cmd_Valid pulses once.
  - Id=10, Len=3, Payload=64'h0000_0000_0033_2211.
- Zero-length frame A5 42 00 42 -> o_Cmd_Valid, Id=42, Len=0, Payload=0.
- Bad checksum A5 10 01 55, then byte 00 (expected 44):
  - o_Frame_Err with Err_Code=1.
  - Previous command outputs unchanged.
- Length 09 after A5 07 -> o_Frame_Err with Err_Code=2; a following good frame decodes normally.
- Stall:
  - A5 10 02 AA, then silence -> o_Frame_Err with Err_Code=3 exactly TIMEOUT_CLKS clocks after AA.
  - Repeat with a byte arriving on the timeout cycle -> no error.
- Noise and reset:
  - Garbage 00 FF 13 before a good frame -> only one o_Cmd_Valid.
  - Assert i_Reset after A5 10 03 11 -> all outputs 0, no strobes.
  - A fresh frame then decodes normally.
